// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and round-robin helpers for the memory port arbiter.
package mem_arb_pkg;
  localparam int NUM_REQ   = 3;
  localparam int REQ_PARAM = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_WB    = 2;
  typedef logic [1:0] req_id_t;
  // Lowest offset from the pointer is assigned last, so it wins.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input req_id_t p);
    logic [NUM_REQ-1:0] g;
    int j;
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(p) + k) % NUM_REQ;
      if (r[j]) g = NUM_REQ'(1) << j;
    end
    return g;
  endfunction
  function automatic req_id_t next_ptr(input req_id_t i);
    return (int'(i) == NUM_REQ - 1) ? req_id_t'(0) : req_id_t'(i + 2'd1);
  endfunction
endpackage

// File: rtl/rd_lat_pipe.sv
// rd_lat_pipe: RD_LAT-deep shift pipeline tracking in-flight reads as {valid, id}.
module rd_lat_pipe import mem_arb_pkg::*; #(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  req_id_t in_id,
  output logic    out_valid,
  output req_id_t out_id,
  output logic    any_valid
);
  logic [RD_LAT-1:0] vld_q, vld_d;
  req_id_t id_q [RD_LAT];
  req_id_t id_d [RD_LAT];
  always_comb begin
    vld_d[0] = in_valid;
    id_d[0] = in_id;
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      id_d[k] = id_q[k-1];
    end
  end
  always_ff @(posedge clk) begin
    vld_q <= rst ? '0 : vld_d;
    id_q <= id_d;
  end
  assign out_valid = vld_q[RD_LAT-1];
  assign out_id = id_q[RD_LAT-1];
  assign any_valid = |vld_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port among three requesters,
// returning read data to the owner after a fixed read latency.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  input  logic                  mem_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);
  req_id_t ptr_q, ptr_d, gid, out_id;
  logic rd_go, out_valid, any_valid;
  always_comb begin
    gnt = (mem_ready && !rst) ? rr_pick(req, ptr_q) : '0;
    gid = gnt[REQ_WB] ? req_id_t'(REQ_WB) : gnt[REQ_DATA] ? req_id_t'(REQ_DATA) : req_id_t'(REQ_PARAM);
    mem_en = |gnt;
    mem_we = mem_en & we[gid];
    mem_addr = mem_en ? addr[gid*ADDR_W +: ADDR_W] : '0;
    mem_wdata = mem_en ? wdata[gid*DATA_W +: DATA_W] : '0;
    rd_go = mem_en & ~we[gid];
    ptr_d = mem_en ? next_ptr(gid) : ptr_q;
    rvalid = (out_valid && !rst) ? NUM_REQ'(1) << out_id : '0;
    busy = any_valid & ~rst;
  end
  assign rdata = mem_rdata;
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk(clk), .rst(rst), .in_valid(rd_go), .in_id(gid),
    .out_valid(out_valid), .out_id(out_id), .any_valid(any_valid)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a read-return scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 32, LAT = 3;
  typedef struct { int due; int id; } exp_t;
  logic clk = 0, rst = 1, mem_ready = 1;
  logic [2:0] req = 0, we = 0, gnt, rvalid;
  logic [3*AW-1:0] addr = 0;
  logic [3*DW-1:0] wdata = 0;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic busy, mem_en, mem_we;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  int rd_g[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = {16'hA5A5, cyc[15:0]};
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy), .mem_ready(mem_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  // Read-return monitor: every rvalid must match the oldest outstanding read at its due cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("rvalid_missing", 32'(sb[0].due), 32'(cyc));
      void'(sb.pop_front());
    end
    if (rvalid != 0) begin
      if (sb.size() == 0) chk("rvalid_unexpected", 32'(rvalid), 0);
      else begin
        int d;
        d = sb[0].due;
        chk("rvalid_cycle", 32'(cyc), 32'(d));
        chk("rvalid_id", 32'(rvalid), 32'(3'b1 << sb[0].id));
        chk("rdata", rdata, {16'hA5A5, d[15:0]});
        void'(sb.pop_front());
      end
    end
  end
  task automatic step(input logic [2:0] eg, input string nm);
    int id;
    logic bexp;
    @(negedge clk);
    id = eg[1] ? 1 : eg[2] ? 2 : 0;
    bexp = 0;
    foreach (rd_g[k]) if (rd_g[k] < cyc && cyc <= rd_g[k] + LAT) bexp = 1;
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    chk({nm, "_mem_en"}, 32'(mem_en), 32'(eg != 0));
    chk({nm, "_busy"}, 32'(busy), 32'(bexp));
    if (eg != 0) begin
      chk({nm, "_mem_we"}, 32'(mem_we), 32'(we[id]));
      chk({nm, "_mem_addr"}, 32'(mem_addr), 32'(addr[id*AW +: AW]));
      chk({nm, "_mem_wdata"}, mem_wdata, wdata[id*DW +: DW]);
      if (!we[id]) begin
        sb.push_back('{cyc + LAT, id});
        rd_g.push_back(cyc);
      end
    end else begin
      chk({nm, "_mem_addr0"}, 32'(mem_addr), 0);
      chk({nm, "_mem_we0"}, 32'(mem_we), 0);
    end
    if (rst) chk({nm, "_rvalid_rst"}, 32'(rvalid), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    req = 3'b111;
    repeat (2) step(3'b000, "reset");
    rst = 0;
    addr = {16'h0300, 16'h0200, 16'h0100};
    wdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    for (int i = 0; i < 6; i++) step(3'b001 << (i % 3), "rr");
    req = 0;
    repeat (4) step(3'b000, "idle_a");
    addr[15:0] = 16'h0010;
    req = 3'b001;
    step(3'b001, "single_rd");
    req = 3'b110;
    mem_ready = 0;
    repeat (3) step(3'b000, "not_ready");
    mem_ready = 1;
    step(3'b010, "ready_again");
    req = 3'b100;
    we = 3'b100;
    addr[32 +: 16] = 16'h00FF;
    wdata[64 +: 32] = 32'hDEAD_BEEF;
    step(3'b100, "wb_write");
    req = 0;
    we = 0;
    repeat (4) step(3'b000, "idle_b");
    req = 3'b011;
    step(3'b001, "b2b_0");
    req = 3'b010;
    step(3'b010, "b2b_1");
    req = 0;
    repeat (5) step(3'b000, "idle_c");
    req = 3'b001;
    step(3'b001, "pre_rst_rd");
    req = 0;
    rst = 1;
    sb.delete();
    rd_g.delete();
    repeat (2) step(3'b000, "in_rst");
    rst = 0;
    repeat (5) step(3'b000, "post_rst");
    req = 3'b111;
    step(3'b001, "first_after_rst");
    req = 0;
    repeat (5) step(3'b000, "drain");
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the word address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 SHALL have parameter RD_LAT, default 1, legal range 1..4, meaning the memory read latency in cycles.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port req, input, 3 bits: request per requester (0 = param fetch, 1 = data fetch, 2 = write-back).
REQ-008 SHALL have port we, input, 3 bits: write enable per requester (1 = write, 0 = read).
REQ-009 SHALL have port addr, input, 3*ADDR_W bits: per-requester address, requester i in slice i.
REQ-010 SHALL have port wdata, input, 3*DATA_W bits: per-requester write data, requester i in slice i.
REQ-011 SHALL have port gnt, output, 3 bits: one-hot grant; transfer occurs when req[i] and gnt[i] are both high.
REQ-012 SHALL have port rvalid, output, 3 bits: one-hot read-data-valid per requester.
REQ-013 SHALL have port rdata, output, DATA_W bits: shared read data, qualified by rvalid.
REQ-014 SHALL have port busy, output, 1 bit: high while any read is in flight.
REQ-015 SHALL have port mem_ready, input, 1 bit: memory can accept an access this cycle.
REQ-016 SHALL have port mem_en, output, 1 bit: memory access strobe.
REQ-017 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-018 SHALL have port mem_addr, output, ADDR_W bits: memory address.
REQ-019 SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-020 SHALL have port mem_rdata, input, DATA_W bits: memory read data, valid RD_LAT cycles after a read strobe.

Function
REQ-021 gnt SHALL be combinational: at most one bit high; gnt[i] only if req[i] and mem_ready.
REQ-022 Selection SHALL be round-robin: search starts at pointer ptr (2 bits, values 0..2) and wraps 2->0.
REQ-023 On a granted transfer to requester i, ptr SHALL become (i+1) mod 3 on the next edge; otherwise ptr SHALL hold.
REQ-024 mem_en SHALL equal OR(gnt); mem_we, mem_addr and mem_wdata SHALL be the granted requester's slices; with no grant they SHALL be 0.
REQ-025 Requesters SHALL hold req, we, addr and wdata stable until granted; the arbiter SHALL NOT buffer requests.
REQ-026 A granted read SHALL raise rvalid[i] for exactly one cycle, exactly RD_LAT cycles after the grant cycle; rdata SHALL pass mem_rdata through in that cycle.
REQ-027 A granted write SHALL produce no rvalid.
REQ-028 Reads SHALL be tracked in an RD_LAT-deep shift pipeline of {valid, id}; one grant per cycle gives back-to-back throughput with no bubbles.
REQ-029 busy SHALL be the OR of all pipeline valid bits.
REQ-030 When mem_ready is 0: gnt SHALL be 0, ptr SHALL hold, and the read pipeline SHALL still advance.
REQ-031 With no req, mem_en SHALL be 0 and ptr SHALL hold.
REQ-032 A requester holding req continuously SHALL be granted at least once every 3 cycles in which mem_ready is 1 (no starvation).

Reset
REQ-033 While rst is high: ptr SHALL be 0, all pipeline valid bits 0, and gnt, rvalid, busy and mem_en SHALL all be 0.
REQ-034 Reset during in-flight reads SHALL discard them; no rvalid SHALL appear after rst deasserts for reads granted before reset.
REQ-035 The first grant after reset SHALL favour requester 0.

Structure
REQ-036 Package mem_arb_pkg SHALL hold NUM_REQ=3 and the requester id constants REQ_PARAM=0, REQ_DATA=1, REQ_WB=2.
REQ-037 The read-tracking pipeline SHALL be a sub-module rd_lat_pipe (parameter RD_LAT, ports in valid/id, out valid/id).

Verification
REQ-038 Single read: req=3'b001, we=0, addr=0x0010 -> gnt=001 and mem_en=1 in the same cycle; rvalid=001 RD_LAT cycles later with rdata=mem_rdata.
REQ-039 All three request continuously from reset -> grant order 0,1,2,0,1,2 in consecutive cycles.
REQ-040 mem_ready=0 for 3 cycles with req=3'b110 -> gnt=0 and ptr unchanged; on mem_ready=1, requester 1 is granted.
REQ-041 Write by requester 2 (addr=0x00FF, wdata=0xDEADBEEF) -> mem_we=1 with matching mem_addr/mem_wdata; no rvalid follows.
REQ-042 RD_LAT=3, reads granted to requesters 0 then 1 in back-to-back cycles -> rvalid=001 then 010 in consecutive cycles; busy high throughout.
REQ-043 Read granted, then rst asserted 1 cycle later -> no rvalid after reset and busy=0.
